packet_generator: RTL and testbench

Transmit-side framing stage directly downstream of `reward`. It captures the `r*` packet fields when `reward` signals completion and serialises them into 16-bit words on a valid/ready stream towards the radio/TX interface. A one-entry pending slot absorbs a second `reward_done` that arrives while a packet is still draining. It also reports drops and completion back to the node controller.

---
 rtl/eer_pkg.sv | 37 +++
 rtl/pkt_slot.sv | 27 ++
 rtl/packet_generator.sv | 165 ++++++++++++++++
 tb/tb_packet_generator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eer_pkg.sv
// Shared types for the EER transmit path: packet fields, packet types and framing lengths.
// Optional feature macro: PKT_CHECKSUM_EN adds a trailing XOR checksum word.
package eer_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    PKT_HB      = 3'd0,
    PKT_CHE     = 3'd1,
    PKT_INV     = 3'd2,
    PKT_JOIN    = 3'd3,
    PKT_DATA    = 3'd4,
    PKT_TIMEOUT = 3'd5
  } pktType_e;

  typedef struct packed {
    logic [2:0]            packetType;
    logic [WORD_WIDTH-1:0] sourceId;
    logic [WORD_WIDTH-1:0] destinationId;
    logic [WORD_WIDTH-1:0] sourceHops;
    logic [WORD_WIDTH-1:0] qValue;
    logic [WORD_WIDTH-1:0] energyLeft;
    logic [WORD_WIDTH-1:0] chosenCh;
    logic [WORD_WIDTH-1:0] hopsFromCh;
  } pktFields_t;

`ifdef PKT_CHECKSUM_EN
  localparam logic [7:0] LEN_HB   = 8'd7;
  localparam logic [7:0] LEN_FULL = 8'd9;
  typedef enum logic [1:0] {IDLE, SEND, CSUM} txState_e;
`else
  localparam logic [7:0] LEN_HB   = 8'd6;
  localparam logic [7:0] LEN_FULL = 8'd8;
  typedef enum logic [1:0] {IDLE, SEND} txState_e;
`endif

endpackage

// File: rtl/pkt_slot.sv
// One packet buffer: the captured field struct plus its occupancy bit.
// Load wins over clear so a slot can be emptied and refilled in the same cycle.
module pkt_slot
  import eer_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       load,
  input  logic       clear,
  input  pktFields_t loadData,
  output pktFields_t data,
  output logic       valid
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= loadData;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_generator.sv
// Frames captured reward fields into a 16-bit valid/ready word stream, with a one-deep pending slot.
// Optional feature macro: PKT_CHECKSUM_EN appends an XOR checksum word carrying EOP.
module packet_generator
  import eer_pkg::*;
#(
  parameter int WORD_WIDTH = eer_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  reward_done,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  pkt_drop
);

  txState_e   state, stateNext;
  logic [3:0] wordIdx, wordIdxNext;
  pktFields_t newFields, actData, pendData, actLoadData;
  logic       actValid, pendValid;
  logic       actLoad, pendLoad, drop;
  logic       isHb, lastField, handshake, finalHs;
  logic [7:0] lenByte;

  assign newFields = '{packetType: rPacketType, sourceId: rSourceID,
                       destinationId: rDestinationID, sourceHops: rSourceHops,
                       qValue: rQValue, energyLeft: rEnergyLeft,
                       chosenCh: rChosenCH, hopsFromCh: rHopsFromCH};

  assign isHb      = (actData.packetType == PKT_HB);
  assign lenByte   = isHb ? LEN_HB : LEN_FULL;
  assign lastField = (wordIdx == (isHb ? 4'd5 : 4'd7));
  assign handshake = tx_valid && tx_ready;
  assign finalHs   = handshake && tx_eop;

  // At the final handshake the pending packet (if any) is promoted and a coincident
  // capture refills whichever slot is free, so nothing is dropped in that cycle.
  always_comb begin
    actLoad     = 1'b0;
    pendLoad    = 1'b0;
    drop        = 1'b0;
    actLoadData = newFields;
    if (finalHs) begin
      actLoad  = pendValid || reward_done;
      pendLoad = pendValid && reward_done;
      if (pendValid) actLoadData = pendData;
    end else if (reward_done) begin
      actLoad  = !actValid;
      pendLoad = actValid && !pendValid;
      drop     = actValid && pendValid;
    end
  end

  pkt_slot activeSlot (
    .clk(clk), .nrst(nrst), .load(actLoad), .clear(finalHs),
    .loadData(actLoadData), .data(actData), .valid(actValid)
  );

  pkt_slot pendingSlot (
    .clk(clk), .nrst(nrst), .load(pendLoad), .clear(finalHs),
    .loadData(newFields), .data(pendData), .valid(pendValid)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      wordIdx  <= 4'd0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      state    <= stateNext;
      wordIdx  <= wordIdxNext;
      busy     <= actLoad || pendLoad || (actValid && !finalHs) || (pendValid && !finalHs);
      tx_done  <= finalHs;
      pkt_drop <= drop;
    end
  end

  always_comb begin
    stateNext   = state;
    wordIdxNext = wordIdx;
    case (state)
      IDLE: begin
        if (actLoad) begin
          stateNext   = SEND;
          wordIdxNext = 4'd0;
        end
      end
      SEND: begin
        if (handshake) begin
          if (lastField) begin
            wordIdxNext = 4'd0;
`ifdef PKT_CHECKSUM_EN
            stateNext   = CSUM;
`else
            stateNext   = actLoad ? SEND : IDLE;
`endif
          end else begin
            wordIdxNext = wordIdx + 4'd1;
          end
        end
      end
`ifdef PKT_CHECKSUM_EN
      CSUM: begin
        if (handshake) begin
          stateNext   = actLoad ? SEND : IDLE;
          wordIdxNext = 4'd0;
        end
      end
`endif
      default: begin
        stateNext   = IDLE;
        wordIdxNext = 4'd0;
      end
    endcase
  end

  // Outputs decode straight from registered state, so they hold through stalls
  // and drop to zero the moment reset is asserted.
  always_comb begin
    tx_data  = '0;
    tx_valid = (state != IDLE);
    tx_sop   = (state == SEND) && (wordIdx == 4'd0);
`ifdef PKT_CHECKSUM_EN
    tx_eop   = (state == CSUM);
`else
    tx_eop   = (state == SEND) && lastField;
`endif
    if (state == SEND) begin
      case (wordIdx)
        4'd0:    tx_data = {actData.packetType, 5'b0, lenByte};
        4'd1:    tx_data = actData.sourceId;
        4'd2:    tx_data = actData.destinationId;
        4'd3:    tx_data = actData.sourceHops;
        4'd4:    tx_data = actData.qValue;
        4'd5:    tx_data = actData.energyLeft;
        4'd6:    tx_data = actData.chosenCh;
        4'd7:    tx_data = actData.hopsFromCh;
        default: tx_data = '0;
      endcase
    end
`ifdef PKT_CHECKSUM_EN
    else if (state == CSUM) begin
      tx_data = {actData.packetType, 5'b0, lenByte} ^ actData.sourceId ^
                actData.destinationId ^ actData.sourceHops ^ actData.qValue ^
                actData.energyLeft ^
                (isHb ? '0 : (actData.chosenCh ^ actData.hopsFromCh));
    end
`endif
  end

endmodule

// File: tb/tb_packet_generator.sv
// Directed self-checking bench for packet_generator; follows PKT_CHECKSUM_EN if defined.
module tb_packet_generator;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        reward_done = 1'b0;
  logic [2:0]  rPacketType = '0;
  logic [15:0] rSourceID = '0, rDestinationID = '0, rSourceHops = '0, rQValue = '0;
  logic [15:0] rEnergyLeft = '0, rChosenCH = '0, rHopsFromCH = '0;
  logic [15:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, busy, tx_done, pkt_drop;
  logic        tx_ready = 1'b0;

  int passCount = 0;
  int checkCount = 0;

  logic [15:0] words[16];
  bit          sops[16];
  bit          eops[16];
  logic [15:0] expWords[16];
  int          expLen;

  packet_generator dut (
    .clk(clk), .nrst(nrst), .reward_done(reward_done), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rSourceHops(rSourceHops),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy),
    .tx_done(tx_done), .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

`ifdef PKT_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  // Reference framing model: header, five common fields, two more for non-HB, optional XOR.
  function automatic void buildExpected(input logic [2:0] t, input logic [15:0] s, d, h, q, e, c, hc);
    logic [15:0] cs;
    int n;
    n = ((t == 3'd0) ? 6 : 8) + EXTRA;
    expWords[0] = {t, 5'b0, 8'(n)};
    expWords[1] = s; expWords[2] = d; expWords[3] = h; expWords[4] = q; expWords[5] = e;
    if (t != 3'd0) begin expWords[6] = c; expWords[7] = hc; end
    if (EXTRA == 1) begin
      cs = '0;
      for (int i = 0; i < n - 1; i++) cs = cs ^ expWords[i];
      expWords[n-1] = cs;
    end
    expLen = n;
  endfunction

  task automatic driveFields(input logic [2:0] t, input logic [15:0] s, d, h, q, e, c, hc);
    rPacketType = t; rSourceID = s; rDestinationID = d; rSourceHops = h;
    rQValue = q; rEnergyLeft = e; rChosenCH = c; rHopsFromCH = hc;
  endtask

  // Receives one packet starting at a negedge; mode 0 keeps ready high, mode 1 stalls every other cycle.
  // Returns at the negedge+1 of the EOP handshake cycle, before that posedge.
  task automatic collect(input int mode, input int budget, output int nWords, output int cycles,
                         output int stallErr, output bit timedOut);
    logic [15:0] prevData;
    logic        prevSop, prevEop;
    bit          seenValid, prevStall;
    nWords = 0; cycles = 0; stallErr = 0; timedOut = 1'b1;
    seenValid = 1'b0; prevStall = 1'b0; prevData = '0; prevSop = 1'b0; prevEop = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tx_ready = (mode == 0) ? 1'b1 : (((cycles + 1) % 2) == 0);
      #1;
      if (tx_valid) seenValid = 1'b1;
      if (seenValid) cycles++;
      if (prevStall && (tx_data !== prevData || tx_sop !== prevSop || tx_eop !== prevEop)) stallErr++;
      prevStall = tx_valid && !tx_ready;
      prevData = tx_data; prevSop = tx_sop; prevEop = tx_eop;
      if (tx_valid && tx_ready && nWords < 16) begin
        words[nWords] = tx_data; sops[nWords] = tx_sop; eops[nWords] = tx_eop;
        nWords++;
        if (tx_eop) begin timedOut = 1'b0; break; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    #3 nrst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkCount++; if (tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); else passCount++;
    checkCount++; if (tx_data !== 16'h0) $display("[TB] FAIL reset_tx_data got %h want 0000", tx_data); else passCount++;
    checkCount++; if (tx_sop !== 1'b0) $display("[TB] FAIL reset_tx_sop got %b want 0", tx_sop); else passCount++;
    checkCount++; if (tx_eop !== 1'b0) $display("[TB] FAIL reset_tx_eop got %b want 0", tx_eop); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passCount++;
    checkCount++; if (tx_done !== 1'b0) $display("[TB] FAIL reset_tx_done got %b want 0", tx_done); else passCount++;
    checkCount++; if (pkt_drop !== 1'b0) $display("[TB] FAIL reset_pkt_drop got %b want 0", pkt_drop); else passCount++;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hb();
    logic [15:0] hand[7];
    int nWords, cycles, stallErr;
    bit timedOut;
    hand[0] = (EXTRA == 1) ? 16'h0007 : 16'h0006;
    hand[1] = 16'h000c; hand[2] = 16'hffff; hand[3] = 16'h0001;
    hand[4] = 16'h0000; hand[5] = 16'h8000; hand[6] = 16'h7ff5;
    driveFields(3'd0, 16'h000c, 16'hffff, 16'h0001, 16'h0000, 16'h8000, 16'h1234, 16'h5678);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    #1;
    checkCount++; if (tx_valid !== 1'b1) $display("[TB] FAIL hb_latency_valid got %b want 1", tx_valid); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL hb_busy_high got %b want 1", busy); else passCount++;
    collect(0, 40, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0) $display("[TB] FAIL hb_timeout got %b want 0", timedOut); else passCount++;
    checkCount++; if (nWords !== 6 + EXTRA) $display("[TB] FAIL hb_len got %0d want %0d", nWords, 6 + EXTRA); else passCount++;
    checkCount++; if (cycles !== 6 + EXTRA) $display("[TB] FAIL hb_cycles got %0d want %0d", cycles, 6 + EXTRA); else passCount++;
    for (int i = 0; i < 6 + EXTRA; i++) begin
      checkCount++; if (words[i] !== hand[i]) $display("[TB] FAIL hb_word%0d got %h want %h", i, words[i], hand[i]); else passCount++;
      checkCount++; if (sops[i] !== (i == 0)) $display("[TB] FAIL hb_sop%0d got %b want %b", i, sops[i], i == 0); else passCount++;
      checkCount++; if (eops[i] !== (i == 5 + EXTRA)) $display("[TB] FAIL hb_eop%0d got %b want %b", i, eops[i], i == 5 + EXTRA); else passCount++;
    end
    @(negedge clk); #1;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL hb_tx_done got %b want 1", tx_done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL hb_busy_low got %b want 0", busy); else passCount++;
    checkCount++; if (tx_valid !== 1'b0) $display("[TB] FAIL hb_idle_valid got %b want 0", tx_valid); else passCount++;
    @(negedge clk); #1;
    checkCount++; if (tx_done !== 1'b0) $display("[TB] FAIL hb_tx_done_pulse got %b want 0", tx_done); else passCount++;
  endtask

  task automatic test_join_stall();
    int nWords, cycles, stallErr;
    bit timedOut;
    @(negedge clk);
    buildExpected(3'd3, 16'h1111, 16'h2222, 16'h0003, 16'h4444, 16'h5555, 16'h0066, 16'h0007);
    driveFields(3'd3, 16'h1111, 16'h2222, 16'h0003, 16'h4444, 16'h5555, 16'h0066, 16'h0007);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    collect(1, 60, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0) $display("[TB] FAIL join_timeout got %b want 0", timedOut); else passCount++;
    checkCount++; if (words[0] !== ((EXTRA == 1) ? 16'h6009 : 16'h6008)) $display("[TB] FAIL join_header got %h want %h", words[0], (EXTRA == 1) ? 16'h6009 : 16'h6008); else passCount++;
    checkCount++; if (nWords !== expLen) $display("[TB] FAIL join_len got %0d want %0d", nWords, expLen); else passCount++;
    checkCount++; if (cycles !== 2 * expLen) $display("[TB] FAIL join_cycles got %0d want %0d", cycles, 2 * expLen); else passCount++;
    checkCount++; if (stallErr !== 0) $display("[TB] FAIL join_stall_stable got %0d changes want 0", stallErr); else passCount++;
    for (int i = 0; i < expLen; i++) begin
      checkCount++; if (words[i] !== expWords[i]) $display("[TB] FAIL join_word%0d got %h want %h", i, words[i], expWords[i]); else passCount++;
    end
    @(negedge clk); #1;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL join_tx_done got %b want 1", tx_done); else passCount++;
  endtask

  task automatic test_back_to_back();
    int nWords, cycles, stallErr;
    bit timedOut;
    @(negedge clk);
    tx_ready = 1'b0;
    driveFields(3'd0, 16'h0a0a, 16'h0b0b, 16'h0002, 16'h0c0c, 16'h0d0d, 16'h0000, 16'h0000);
    reward_done = 1'b1;
    @(negedge clk);
    driveFields(3'd4, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707);
    @(negedge clk);
    driveFields(3'd1, 16'hdead, 16'hbeef, 16'h0009, 16'h0008, 16'h0007, 16'h0006, 16'h0005);
    #1;
    checkCount++; if (pkt_drop !== 1'b0) $display("[TB] FAIL b2b_no_early_drop got %b want 0", pkt_drop); else passCount++;
    @(negedge clk);
    reward_done = 1'b0;
    #1;
    checkCount++; if (pkt_drop !== 1'b1) $display("[TB] FAIL b2b_drop got %b want 1", pkt_drop); else passCount++;
    checkCount++; if (tx_data !== ((EXTRA == 1) ? 16'h0007 : 16'h0006)) $display("[TB] FAIL b2b_hold_header got %h", tx_data); else passCount++;
    buildExpected(3'd0, 16'h0a0a, 16'h0b0b, 16'h0002, 16'h0c0c, 16'h0d0d, 16'h0000, 16'h0000);
    collect(0, 40, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0 || nWords !== expLen) $display("[TB] FAIL b2b_first_len got %0d want %0d", nWords, expLen); else passCount++;
    for (int i = 0; i < expLen; i++) begin
      checkCount++; if (words[i] !== expWords[i]) $display("[TB] FAIL b2b_first_word%0d got %h want %h", i, words[i], expWords[i]); else passCount++;
    end
    @(negedge clk); #1;
    checkCount++; if (tx_valid !== 1'b1) $display("[TB] FAIL b2b_no_gap got %b want 1", tx_valid); else passCount++;
    checkCount++; if (tx_sop !== 1'b1) $display("[TB] FAIL b2b_second_sop got %b want 1", tx_sop); else passCount++;
    checkCount++; if (tx_data !== ((EXTRA == 1) ? 16'h8009 : 16'h8008)) $display("[TB] FAIL b2b_second_header got %h want %h", tx_data, (EXTRA == 1) ? 16'h8009 : 16'h8008); else passCount++;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL b2b_first_done got %b want 1", tx_done); else passCount++;
    buildExpected(3'd4, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707);
    collect(0, 40, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0 || nWords !== expLen) $display("[TB] FAIL b2b_second_len got %0d want %0d", nWords, expLen); else passCount++;
    for (int i = 0; i < expLen; i++) begin
      checkCount++; if (words[i] !== expWords[i]) $display("[TB] FAIL b2b_second_word%0d got %h want %h", i, words[i], expWords[i]); else passCount++;
    end
    @(negedge clk); #1;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL b2b_second_done got %b want 1", tx_done); else passCount++;
    checkCount++; if (tx_valid !== 1'b0) $display("[TB] FAIL b2b_dropped_not_sent got %b want 0", tx_valid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_low got %b want 0", busy); else passCount++;
  endtask

  task automatic test_coincident();
    int nWords, cycles, stallErr;
    bit timedOut;
    @(negedge clk);
    driveFields(3'd0, 16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0035, 16'h0000, 16'h0000);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    collect(0, 40, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0) $display("[TB] FAIL coin_first_timeout got %b want 0", timedOut); else passCount++;
    driveFields(3'd2, 16'h00a1, 16'h00a2, 16'h00a3, 16'h00a4, 16'h00a5, 16'h00a6, 16'h00a7);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    #1;
    checkCount++; if (tx_valid !== 1'b1) $display("[TB] FAIL coin_next_valid got %b want 1", tx_valid); else passCount++;
    checkCount++; if (tx_data !== ((EXTRA == 1) ? 16'h4009 : 16'h4008)) $display("[TB] FAIL coin_next_header got %h want %h", tx_data, (EXTRA == 1) ? 16'h4009 : 16'h4008); else passCount++;
    checkCount++; if (pkt_drop !== 1'b0) $display("[TB] FAIL coin_no_drop got %b want 0", pkt_drop); else passCount++;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL coin_first_done got %b want 1", tx_done); else passCount++;
    buildExpected(3'd2, 16'h00a1, 16'h00a2, 16'h00a3, 16'h00a4, 16'h00a5, 16'h00a6, 16'h00a7);
    collect(0, 40, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0 || nWords !== expLen) $display("[TB] FAIL coin_second_len got %0d want %0d", nWords, expLen); else passCount++;
    for (int i = 0; i < expLen; i++) begin
      checkCount++; if (words[i] !== expWords[i]) $display("[TB] FAIL coin_word%0d got %h want %h", i, words[i], expWords[i]); else passCount++;
    end
    @(negedge clk); #1;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL coin_second_done got %b want 1", tx_done); else passCount++;
  endtask

  task automatic test_reset_mid();
    int nWords, cycles, stallErr;
    bit timedOut, sawValid, sawDone;
    @(negedge clk);
    tx_ready = 1'b1;
    driveFields(3'd0, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0000, 16'h0000);
    reward_done = 1'b1;
    @(negedge clk);
    driveFields(3'd5, 16'h0f01, 16'h0f02, 16'h0f03, 16'h0f04, 16'h0f05, 16'h0f06, 16'h0f07);
    @(negedge clk);
    reward_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkCount++; if (tx_data !== 16'h0303) $display("[TB] FAIL rst_mid_word3 got %h want 0303", tx_data); else passCount++;
    nrst = 1'b0;
    #1;
    checkCount++; if (tx_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid got %b want 0", tx_valid); else passCount++;
    checkCount++; if (tx_data !== 16'h0) $display("[TB] FAIL rst_mid_data got %h want 0000", tx_data); else passCount++;
    checkCount++; if (tx_sop !== 1'b0 || tx_eop !== 1'b0) $display("[TB] FAIL rst_mid_sop_eop got %b%b want 00", tx_sop, tx_eop); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy got %b want 0", busy); else passCount++;
    @(negedge clk);
    nrst = 1'b1;
    sawValid = 1'b0; sawDone = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (tx_valid) sawValid = 1'b1;
      if (tx_done) sawDone = 1'b1;
    end
    checkCount++; if (sawValid !== 1'b0) $display("[TB] FAIL rst_mid_pending_lost got %b want 0", sawValid); else passCount++;
    checkCount++; if (sawDone !== 1'b0) $display("[TB] FAIL rst_mid_no_done got %b want 0", sawDone); else passCount++;
    @(negedge clk);
    buildExpected(3'd0, 16'h0c0c, 16'h0d0d, 16'h0004, 16'h0e0e, 16'h0f0f, 16'h0000, 16'h0000);
    driveFields(3'd0, 16'h0c0c, 16'h0d0d, 16'h0004, 16'h0e0e, 16'h0f0f, 16'h0000, 16'h0000);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    collect(0, 40, nWords, cycles, stallErr, timedOut);
    checkCount++; if (timedOut !== 1'b0 || nWords !== expLen) $display("[TB] FAIL rst_mid_new_len got %0d want %0d", nWords, expLen); else passCount++;
    for (int i = 0; i < expLen; i++) begin
      checkCount++; if (words[i] !== expWords[i]) $display("[TB] FAIL rst_mid_new_word%0d got %h want %h", i, words[i], expWords[i]); else passCount++;
    end
    checkCount++; if (sops[0] !== 1'b1) $display("[TB] FAIL rst_mid_new_sop got %b want 1", sops[0]); else passCount++;
    @(negedge clk); #1;
    checkCount++; if (tx_done !== 1'b1) $display("[TB] FAIL rst_mid_new_done got %b want 1", tx_done); else passCount++;
  endtask

  initial begin
    $display("[TB] packet_generator bench start");
    test_reset();
    test_hb();
    test_join_stall();
    test_back_to_back();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
